// File: rtl/ifns_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_pkg
//  Description : Shared widths, types and Fibonacci weights for the FNS decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifns_pkg;

    localparam int CW_W   = 26;
    localparam int DATA_W = 18;
    localparam int HALF_W = CW_W / 2;
    // The high half alone can reach 317201, so partial sums carry the range bit too.
    localparam int SUM_W  = DATA_W + 1;

    typedef logic [CW_W-1:0]   ifns_cw_t;
    typedef logic [DATA_W-1:0] ifns_data_t;
    typedef logic [SUM_W-1:0]  ifns_sum_t;

    localparam ifns_sum_t FIB_W [1:CW_W] = '{
        19'd1,     19'd1,     19'd2,     19'd3,     19'd5,
        19'd8,     19'd13,    19'd21,    19'd34,    19'd55,
        19'd89,    19'd144,   19'd233,   19'd377,   19'd610,
        19'd987,   19'd1597,  19'd2584,  19'd4181,  19'd6765,
        19'd10946, 19'd17711, 19'd28657, 19'd46368, 19'd75025,
        19'd121393
    };

endpackage
`default_nettype wire

// File: rtl/ifns_decoder_18di_core_partial_sum.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_partial_sum
//  Description : Weighted sum of 13 codeword bits starting at weight index BASE.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifns_partial_sum
    import ifns_pkg::*;
#(
    parameter int BASE = 1
) (
    input  logic [HALF_W-1:0] i_bits,
    output ifns_sum_t         o_sum
);

    always_comb begin
        o_sum = '0;
        for (int k = 0; k < HALF_W; k++) begin
            if (i_bits[k]) begin
                o_sum = o_sum + FIB_W[BASE + k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifns_decoder_18di_core.sv
`default_nettype none
// ============================================================================
//  Module      : ifns_decoder_18di_core
//  Description : 3-stage streaming FNS codeword decoder with range flag and
//                saturating delivery/error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifns_decoder_18di_core
    import ifns_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cw_valid,
    output logic             cw_ready,
    input  ifns_cw_t         cw,
    output logic             v_valid,
    input  logic             v_ready,
    output ifns_data_t       v,
    output logic             v_range_err,
    output logic [CNT_W-1:0] words_cnt,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    logic             w_advance;
    logic             w_deliver;
    ifns_sum_t        w_lo_sum;
    ifns_sum_t        w_hi_sum;

    logic             r_s1_vld_q, w_s1_vld_d;
    ifns_cw_t         r_s1_cw_q,  w_s1_cw_d;
    logic             r_s2_vld_q, w_s2_vld_d;
    ifns_sum_t        r_s2_lo_q,  w_s2_lo_d;
    ifns_sum_t        r_s2_hi_q,  w_s2_hi_d;
    logic             r_s3_vld_q, w_s3_vld_d;
    ifns_sum_t        r_s3_sum_q, w_s3_sum_d;
    logic [CNT_W-1:0] r_words_q,  w_words_d;
    logic [CNT_W-1:0] r_err_q,    w_err_d;

    ifns_partial_sum #(.BASE(1)) u_lo_sum (
        .i_bits (r_s1_cw_q[HALF_W-1:0]),
        .o_sum  (w_lo_sum)
    );

    ifns_partial_sum #(.BASE(HALF_W + 1)) u_hi_sum (
        .i_bits (r_s1_cw_q[CW_W-1:HALF_W]),
        .o_sum  (w_hi_sum)
    );

    always_comb begin
        w_advance  = !r_s3_vld_q || v_ready;
        w_deliver  = r_s3_vld_q && v_ready;

        w_s1_vld_d = r_s1_vld_q;
        w_s1_cw_d  = r_s1_cw_q;
        w_s2_vld_d = r_s2_vld_q;
        w_s2_lo_d  = r_s2_lo_q;
        w_s2_hi_d  = r_s2_hi_q;
        w_s3_vld_d = r_s3_vld_q;
        w_s3_sum_d = r_s3_sum_q;
        w_words_d  = r_words_q;
        w_err_d    = r_err_q;

        // Whole pipe shifts together; bubbles keep their slot.
        if (w_advance) begin
            w_s1_vld_d = cw_valid;
            w_s1_cw_d  = cw;
            w_s2_vld_d = r_s1_vld_q;
            w_s2_lo_d  = w_lo_sum;
            w_s2_hi_d  = w_hi_sum;
            w_s3_vld_d = r_s2_vld_q;
            if (r_s2_vld_q) begin
                w_s3_sum_d = r_s2_lo_q + r_s2_hi_q;
            end
        end

        if (clr_cnt) begin
            w_words_d = '0;
            w_err_d   = '0;
        end else if (w_deliver) begin
            if (r_words_q != {CNT_W{1'b1}}) begin
                w_words_d = r_words_q + 1'b1;
            end
            if (r_s3_sum_q[DATA_W] && (r_err_q != {CNT_W{1'b1}})) begin
                w_err_d = r_err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld_q <= 1'b0;
            r_s1_cw_q  <= '0;
            r_s2_vld_q <= 1'b0;
            r_s2_lo_q  <= '0;
            r_s2_hi_q  <= '0;
            r_s3_vld_q <= 1'b0;
            r_s3_sum_q <= '0;
            r_words_q  <= '0;
            r_err_q    <= '0;
        end else begin
            r_s1_vld_q <= w_s1_vld_d;
            r_s1_cw_q  <= w_s1_cw_d;
            r_s2_vld_q <= w_s2_vld_d;
            r_s2_lo_q  <= w_s2_lo_d;
            r_s2_hi_q  <= w_s2_hi_d;
            r_s3_vld_q <= w_s3_vld_d;
            r_s3_sum_q <= w_s3_sum_d;
            r_words_q  <= w_words_d;
            r_err_q    <= w_err_d;
        end
    end

    assign cw_ready    = w_advance;
    assign v_valid     = r_s3_vld_q;
    assign v           = r_s3_sum_q[DATA_W-1:0];
    assign v_range_err = r_s3_sum_q[DATA_W];
    assign words_cnt   = r_words_q;
    assign err_cnt     = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifns_decoder_18di_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifns_decoder_18di_core
//  Description : Self-checking bench for the FNS decoder (16-bit and 2-bit counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifns_decoder_18di_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cw_valid = 1'b0;
    logic        v_ready = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [25:0] cw = '0;

    logic        cw_ready, v_valid, v_range_err;
    logic [17:0] v;
    logic [15:0] words_cnt, err_cnt;
    logic        cw_ready_s, v_valid_s, v_range_err_s;
    logic [17:0] v_s;
    logic [1:0]  words_cnt_s, err_cnt_s;

    always #5 clk = ~clk;

    ifns_decoder_18di_core #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw_ready(cw_ready), .cw(cw),
        .v_valid(v_valid), .v_ready(v_ready), .v(v), .v_range_err(v_range_err),
        .words_cnt(words_cnt), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
    );

    ifns_decoder_18di_core #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw_ready(cw_ready_s), .cw(cw),
        .v_valid(v_valid_s), .v_ready(v_ready), .v(v_s), .v_range_err(v_range_err_s),
        .words_cnt(words_cnt_s), .err_cnt(err_cnt_s), .clr_cnt(clr_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: value = sum of Fibonacci weights of the set bits.
    int fibw [1:26];
    initial begin
        fibw[1] = 1;
        fibw[2] = 1;
        for (int k = 3; k <= 26; k++) fibw[k] = fibw[k-1] + fibw[k-2];
    end

    function automatic int wsum(input logic [25:0] c);
        int s = 0;
        for (int k = 1; k <= 26; k++) if (c[k-1]) s += fibw[k];
        return s;
    endfunction

    // Three-slot occupancy model: all slots shift on advance, bubbles included.
    bit pv [3];
    int psum [3];
    int pacc [3];
    int cyc = 0;
    int m_w16 = 0, m_e16 = 0, m_w2 = 0, m_e2 = 0;
    int log_v[$], log_e[$], log_lat[$], log_cyc[$];
    bit adv;

    always @(negedge clk) begin
        chk("cw_ready", cw_ready, longint'(!pv[2] || v_ready));
        chk("cw_ready_s", cw_ready_s, longint'(!pv[2] || v_ready));
        chk("v_valid", v_valid, longint'(pv[2]));
        chk("v_valid_s", v_valid_s, longint'(pv[2]));
        if (pv[2]) begin
            chk("v", v, psum[2] % 262144);
            chk("v_range_err", v_range_err, longint'(psum[2] >= 262144));
            chk("v_s", v_s, psum[2] % 262144);
            chk("v_range_err_s", v_range_err_s, longint'(psum[2] >= 262144));
        end
        chk("words_cnt", words_cnt, m_w16);
        chk("err_cnt", err_cnt, m_e16);
        chk("words_cnt_s", words_cnt_s, m_w2);
        chk("err_cnt_s", err_cnt_s, m_e2);

        if (rst) begin
            for (int i = 0; i < 3; i++) pv[i] = 1'b0;
            m_w16 = 0; m_e16 = 0; m_w2 = 0; m_e2 = 0;
        end else begin
            adv = !pv[2] || v_ready;
            if (pv[2] && v_ready) begin
                log_v.push_back(psum[2] % 262144);
                log_e.push_back(psum[2] >= 262144 ? 1 : 0);
                log_lat.push_back(cyc - pacc[2]);
                log_cyc.push_back(cyc);
                if (m_w16 < 65535) m_w16++;
                if (m_w2 < 3) m_w2++;
                if (psum[2] >= 262144) begin
                    if (m_e16 < 65535) m_e16++;
                    if (m_e2 < 3) m_e2++;
                end
            end
            if (clr_cnt) begin
                m_w16 = 0; m_e16 = 0; m_w2 = 0; m_e2 = 0;
            end
            if (adv) begin
                for (int i = 2; i > 0; i--) begin
                    pv[i] = pv[i-1]; psum[i] = psum[i-1]; pacc[i] = pacc[i-1];
                end
                pv[0] = cw_valid; psum[0] = wsum(cw); pacc[0] = cyc;
            end
        end
        cyc++;
    end

    logic [25:0] stim [0:9999];
    bit saw_low;

    task automatic run(input int n, input int vpct, input int rpct,
                       input int stall_at, input int stall_len);
        int idx = 0;
        int k = 0;
        while (idx < n && k < 20 * n + 100) begin
            @(posedge clk); #2;
            cw_valid = ($urandom_range(99) < vpct);
            cw       = stim[idx];
            v_ready  = (k >= stall_at && k < stall_at + stall_len) ? 1'b0
                                                                    : ($urandom_range(99) < rpct);
            #1;
            if (!cw_ready) saw_low = 1'b1;
            if (cw_valid && cw_ready) idx++;
            k++;
        end
        chk("run_accepted", idx, n);
        @(posedge clk); #2;
        cw_valid = 1'b0;
    endtask

    task automatic drain();
        cw_valid = 1'b0;
        v_ready  = 1'b1;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_v_valid", v_valid, 0);
        chk("rst_v", v, 0);
        chk("rst_v_range_err", v_range_err, 0);
        chk("rst_words_cnt", words_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("cw_ready_after_rst", cw_ready, 1);

        // Single zero word: value 0, three-cycle latency.
        stim[0] = 26'd0;
        run(1, 100, 100, -1, 0);
        drain();
        chk("zero_v", log_v[0], 0);
        chk("zero_err", log_e[0], 0);
        chk("zero_latency", log_lat[0], 3);
        chk("zero_words_cnt", words_cnt, 1);

        // Back-to-back: d26, d25|d26, d1|d2.
        stim[0] = 26'h2000000;
        stim[1] = 26'h3000000;
        stim[2] = 26'h0000003;
        run(3, 100, 100, -1, 0);
        drain();
        chk("b2b_v0", log_v[1], 121393);
        chk("b2b_v1", log_v[2], 196418);
        chk("b2b_v2", log_v[3], 2);
        chk("b2b_err", log_e[1] + log_e[2] + log_e[3], 0);
        chk("b2b_gap01", log_cyc[2] - log_cyc[1], 1);
        chk("b2b_gap12", log_cyc[3] - log_cyc[2], 1);

        // All ones: 317810 overflows 2^18 by 55666.
        stim[0] = 26'h3FFFFFF;
        run(1, 100, 100, -1, 0);
        drain();
        chk("ones_v", log_v[4], 55666);
        chk("ones_err", log_e[4], 1);
        chk("ones_err_cnt", err_cnt, 1);
        chk("ones_words_cnt_s_sat", words_cnt_s, 3);

        // Five words with a 4-cycle downstream stall.
        do_reset();
        for (int i = 0; i < 5; i++) stim[i] = 26'd1 << i;
        saw_low = 1'b0;
        run(5, 100, 100, 3, 4);
        drain();
        chk("stall_cw_ready_low", saw_low, 1);
        chk("stall_w0", log_v[5], 1);
        chk("stall_w1", log_v[6], 1);
        chk("stall_w2", log_v[7], 2);
        chk("stall_w3", log_v[8], 3);
        chk("stall_w4", log_v[9], 5);
        chk("stall_words_cnt", words_cnt, 5);
        chk("stall_log_size", log_v.size(), 10);

        // Reset with three words in flight: none delivered or counted.
        stim[0] = 26'h0000100;
        stim[1] = 26'h3FFFFFF;
        stim[2] = 26'h0000055;
        run(3, 100, 0, -1, 0);
        rst = 1'b1;
        v_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("flush_log_size", log_v.size(), 10);
        chk("flush_words_cnt", words_cnt, 0);
        chk("flush_err_cnt", err_cnt, 0);

        // Random traffic with random valid/ready.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(15))
                0:       stim[i] = 26'h3FFFFFF;
                1:       stim[i] = 26'h0;
                default: stim[i] = 26'($urandom);
            endcase
        end
        run(10000, 70, 70, -1, 0);
        drain();
        chk("rand_words_cnt", words_cnt, 10000);
        chk("rand_words_cnt_s_sat", words_cnt_s, 3);
        chk("rand_err_cnt_s_sat", err_cnt_s, 3);

        clr_cnt = 1'b1;
        @(posedge clk); #2;
        clr_cnt = 1'b0;
        chk("clr_words_cnt_s", words_cnt_s, 0);
        chk("clr_err_cnt_s", err_cnt_s, 0);
        chk("clr_words_cnt", words_cnt, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
